// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and pixel colour type for the scan controller slice.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    localparam rgb24_t DEF_BG_RGB = 24'h000000;

    // True when coordinate c lies in [lo, lo+len).
    function automatic logic in_window(input logic [CNT_W-1:0] c, input int lo, input int len);
        return (int'(c) >= lo) && (int'(c) < lo + len);
    endfunction

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// Scan-coordinate / tile-colour bus between the scan controller and the tile ROM.
interface vga_scan_ctrl_if;
    import vga_timing_pkg::*;

    logic [CNT_W-1:0] Q_X;
    logic [CNT_W-1:0] Q_Y;
    logic [7:0]       tile_R;
    logic [7:0]       tile_G;
    logic [7:0]       tile_B;
    logic             tile_visible;

    modport master (output Q_X, Q_Y, input tile_R, tile_G, tile_B, tile_visible);
    modport slave  (input Q_X, Q_Y, output tile_R, tile_G, tile_B, tile_visible);

endinterface

// File: rtl/vga_scan_ctrl_pix_tick_gen.sv
// System-clock divider producing a one-clock strobe at each pixel boundary.
module pix_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Gated by rst_n so a divide-by-one strobe is still low during reset.
    assign pix_tick = rst_n && (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: h/v counters drive the tile ROM, and a one-slot output
// register keeps colour, blank and syncs mutually aligned.
module vga_scan_ctrl
    import vga_timing_pkg::*;
#(
    parameter int     CLK_DIV  = 2,
    parameter int     H_ACTIVE = DEF_H_ACTIVE,
    parameter int     H_FP     = DEF_H_FP,
    parameter int     H_SYNC   = DEF_H_SYNC,
    parameter int     H_BP     = DEF_H_BP,
    parameter int     V_ACTIVE = DEF_V_ACTIVE,
    parameter int     V_FP     = DEF_V_FP,
    parameter int     V_SYNC   = DEF_V_SYNC,
    parameter int     V_BP     = DEF_V_BP,
    parameter rgb24_t BG_RGB   = DEF_BG_RGB
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vga_scan_ctrl_if.master        tile,
    output logic [7:0]             vga_R,
    output logic [7:0]             vga_G,
    output logic [7:0]             vga_B,
    output logic                   hsync_n,
    output logic                   vsync_n,
    output logic                   blank_n,
    output logic                   pix_tick,
    output logic                   frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);

    function automatic rgb24_t pick_colour(input logic active, input logic visible,
                                           input rgb24_t tile_rgb, input rgb24_t bg);
        if (!active) return '0;
        return visible ? tile_rgb : bg;
    endfunction

    logic             vld_p0;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_pix_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_tick (vld_p0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (vld_p0) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    assign tile.Q_X    = h_cnt;
    assign tile.Q_Y    = v_cnt;
    assign pix_tick    = vld_p0;
    assign frame_start = vld_p0 && (h_cnt == '0) && (v_cnt == '0);

    // Stage p0: decode of the slot currently presented on Q_X/Q_Y.
    logic   active_p0;
    logic   hs_p0;
    logic   vs_p0;
    rgb24_t tile_rgb_p0;
    rgb24_t rgb_p0;

    always_comb begin
        active_p0   = in_window(h_cnt, 0, H_ACTIVE) && in_window(v_cnt, 0, V_ACTIVE);
        hs_p0       = in_window(h_cnt, H_ACTIVE + H_FP, H_SYNC);
        vs_p0       = in_window(v_cnt, V_ACTIVE + V_FP, V_SYNC);
        tile_rgb_p0 = {tile.tile_R, tile.tile_G, tile.tile_B};
        rgb_p0      = pick_colour(active_p0, tile.tile_visible, tile_rgb_p0, BG_RGB);
    end

    // Stage p1: capture the ending slot on its tick; syncs idle high in reset.
    rgb24_t rgb_p1;
    logic   blank_n_p1;
    logic   hsync_n_p1;
    logic   vsync_n_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_p1     <= '0;
            blank_n_p1 <= 1'b0;
            hsync_n_p1 <= 1'b1;
            vsync_n_p1 <= 1'b1;
        end else if (vld_p0) begin
            rgb_p1     <= rgb_p0;
            blank_n_p1 <= active_p0;
            hsync_n_p1 <= ~hs_p0;
            vsync_n_p1 <= ~vs_p0;
        end
    end

    assign vga_R   = rgb_p1.r;
    assign vga_G   = rgb_p1.g;
    assign vga_B   = rgb_p1.b;
    assign blank_n = blank_n_p1;
    assign hsync_n = hsync_n_p1;
    assign vsync_n = vsync_n_p1;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench: 640x480 timing at CLK_DIV=2, plus a shrunken-timing CLK_DIV=1 instance for frame checks.
module tb_vga_scan_ctrl;
    import vga_timing_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst1_n = 1'b0;
    initial forever #5 clk = ~clk;

    vga_scan_ctrl_if tif();
    vga_scan_ctrl_if tif1();

    logic [7:0] vr, vg, vb, vr1, vg1, vb1;
    logic hs_n, vs_n, bl_n, ptick, fstart;
    logic hs1_n, vs1_n, bl1_n, ptick1, fstart1;

    vga_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tile(tif),
        .vga_R(vr), .vga_G(vg), .vga_B(vb),
        .hsync_n(hs_n), .vsync_n(vs_n), .blank_n(bl_n),
        .pix_tick(ptick), .frame_start(fstart)
    );

    vga_scan_ctrl #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .BG_RGB(24'h123456)
    ) dut1 (
        .clk(clk), .rst_n(rst1_n), .tile(tif1),
        .vga_R(vr1), .vga_G(vg1), .vga_B(vb1),
        .hsync_n(hs1_n), .vsync_n(vs1_n), .blank_n(bl1_n),
        .pix_tick(ptick1), .frame_start(fstart1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    int n, t0, period, lowcnt, first_low, line1;
    int vlow, vfirst_x, vfirst_y, tick_zero;
    logic [23:0] bg_seen;
    logic [9:0] px, py;

    initial begin
        tif.tile_R = 8'd0; tif.tile_G = 8'd0; tif.tile_B = 8'd0; tif.tile_visible = 1'b0;
        tif1.tile_R = 8'd1; tif1.tile_G = 8'd2; tif1.tile_B = 8'd3; tif1.tile_visible = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_qx", tif.Q_X, 0);
        check("rst_qy", tif.Q_Y, 0);
        check("rst_rgb", {vr, vg, vb}, 0);
        check("rst_blank", bl_n, 0);
        check("rst_hsync", hs_n, 1);
        check("rst_vsync", vs_n, 1);
        check("rst_tick", ptick, 0);
        check("rst_fstart", fstart, 0);
        check("rst_tick_div1", ptick1, 0);

        // Release: first tick in clk 2, Q_X steps every 2 clks
        rst_n = 1'b1;
        rst1_n = 1'b1;
        step();
        check("rel_tick1", ptick, 1);
        check("rel_fstart1", fstart, 1);
        check("rel_qx0", tif.Q_X, 0);
        check("rel_blank_held", bl_n, 0);
        step();
        check("rel_qx1", tif.Q_X, 1);
        check("rel_tick_low", ptick, 0);
        check("rel_blank_active", bl_n, 1);
        step(); step();
        check("rel_qx2", tif.Q_X, 2);

        // Colour gating
        n = 0;
        while (!(tif.Q_X == 5 && !ptick) && n < 100) begin step(); n++; end
        tif.tile_R = 8'd10; tif.tile_G = 8'd20; tif.tile_B = 8'd30; tif.tile_visible = 1'b1;
        step(); step();
        check("col_qx6", tif.Q_X, 6);
        check("col_tile", {vr, vg, vb}, 24'h0a141e);
        check("col_blank", bl_n, 1);
        tif.tile_R = 8'd200; tif.tile_G = 8'd200; tif.tile_B = 8'd200;
        step();
        check("col_hold_midslot", {vr, vg, vb}, 24'h0a141e);
        tif.tile_visible = 1'b0;
        step();
        check("col_bg", {vr, vg, vb}, 24'h000000);
        check("col_bg_blank", bl_n, 1);
        n = 0;
        while (!(tif.Q_X == 700 && !ptick) && n < 2000) begin step(); n++; end
        tif.tile_R = 8'd10; tif.tile_G = 8'd20; tif.tile_B = 8'd30; tif.tile_visible = 1'b1;
        step(); step();
        check("porch_qx701", tif.Q_X, 701);
        check("porch_rgb", {vr, vg, vb}, 0);
        check("porch_blank", bl_n, 0);

        // Line timing
        n = 0;
        while (!(ptick && tif.Q_X == 0) && n < 4000) begin step(); n++; end
        t0 = cyc; lowcnt = 0; first_low = -1;
        step();
        n = 0;
        while (!(ptick && tif.Q_X == 0) && n < 4000) begin
            if (ptick && !hs_n) begin
                lowcnt++;
                if (first_low < 0) first_low = int'(tif.Q_X);
            end
            step(); n++;
        end
        period = cyc - t0;
        check("line_period", period, 1600);
        check("hsync_low_ticks", lowcnt, 96);
        check("hsync_first_low_qx", first_low, 657);

        // Async reset mid-slot at (300,2)
        n = 0;
        while (!(tif.Q_X == 300 && tif.Q_Y == 2 && !ptick) && n < 4000) begin step(); n++; end
        check("pre_rst_rgb", {vr, vg, vb}, 24'h0a141e);
        #2 rst_n = 1'b0;
        #1;
        check("arst_qx", tif.Q_X, 0);
        check("arst_qy", tif.Q_Y, 0);
        check("arst_rgb", {vr, vg, vb}, 0);
        check("arst_blank", bl_n, 0);
        check("arst_hsync", hs_n, 1);
        check("arst_vsync", vs_n, 1);
        check("arst_tick", ptick, 0);
        step(); step();
        check("arst_fstart", fstart, 0);
        rst_n = 1'b1;
        step();
        check("rerel_fstart", fstart, 1);
        check("rerel_qxy", {tif.Q_X, tif.Q_Y}, 0);
        step();
        check("rerel_qx1", tif.Q_X, 1);

        // Small-timing instance: reset during hsync low must not glitch
        n = 0;
        while (!(tif1.Q_X == 12 && tif1.Q_Y == 2) && n < 400) begin step(); n++; end
        check("d1_hsync_low", hs1_n, 0);
        #2 rst1_n = 1'b0;
        #1;
        check("d1_arst_hsync", hs1_n, 1);
        check("d1_arst_tick", ptick1, 0);
        check("d1_arst_qxy", {tif1.Q_X, tif1.Q_Y}, 0);
        step();
        rst1_n = 1'b1;
        #1;
        check("d1_tick_on_release", ptick1, 1);
        check("d1_fstart_on_release", fstart1, 1);

        // Frame timing, CLK_DIV=1
        t0 = cyc; line1 = -1; vlow = 0; vfirst_x = -1; vfirst_y = -1; tick_zero = 0;
        bg_seen = 24'hx; px = 10'd0; py = 10'd0;
        step();
        n = 0;
        while (!fstart1 && n < 1000) begin
            if (!ptick1) tick_zero++;
            if (tif1.Q_X == 0 && line1 < 0) line1 = cyc - t0;
            if (tif1.Q_X == 1 && tif1.Q_Y == 0) bg_seen = {vr1, vg1, vb1};
            if (!vs1_n) begin
                vlow++;
                if (vfirst_x < 0) begin vfirst_x = int'(tif1.Q_X); vfirst_y = int'(tif1.Q_Y); end
            end
            px = tif1.Q_X; py = tif1.Q_Y;
            step(); n++;
        end
        check("d1_frame_period", cyc - t0, 120);
        check("d1_line_period", line1, 15);
        check("d1_tick_const", tick_zero, 0);
        check("d1_vsync_low_ticks", vlow, 30);
        check("d1_vsync_first_low", {vfirst_y[9:0], vfirst_x[9:0]}, {10'd5, 10'd1});
        check("d1_wrap", {px, py, tif1.Q_X, tif1.Q_Y}, {10'd14, 10'd7, 10'd0, 10'd0});
        check("d1_bg", bg_seen, 24'h123456);
        tif1.tile_R = 8'd7; tif1.tile_G = 8'd8; tif1.tile_B = 8'd9; tif1.tile_visible = 1'b1;
        step();
        check("d1_tile", {vr1, vg1, vb1}, 24'h070809);
        tif1.tile_visible = 1'b0;
        step();
        check("d1_bg2", {vr1, vg1, vb1}, 24'h123456);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
